// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: default sizes,
// pointer wrap helper, count-width helper and the per-cycle operation kind.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 16;
   localparam int unsigned FIFO_DEPTH_DEF = 8;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_RD    = 2'b01,
      OP_WR    = 2'b10,
      OP_WR_RD = 2'b11
   } fifo_op_e;

   // Explicit wrap so non-power-of-2 depths never index past the last entry
   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// Occupancy flags derived combinationally from a registered count.
module fifo_flag_gen #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 1,
   parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
   input  logic [CW-1:0] count_i,
   output logic          full_o,
   output logic          empty_o,
   output logic          almostfull_o,
   output logic          almostempty_o
);

   always_comb begin
      full_o        = (count_i == CW'(DEPTH));
      empty_o       = (count_i == '0);
      almostfull_o  = (count_i >= CW'(AF_THRESH)) && !full_o;
      almostempty_o = !empty_o && (count_i <= CW'(AE_THRESH));
   end

endmodule

// File: rtl/prog_sync_fifo.sv
// Parametrised single-clock FIFO with programmable thresholds and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module prog_sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
   parameter int unsigned AE_THRESH  = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush,
   input  logic                                wr_en,
   input  logic [FIFO_WIDTH-1:0]               data_in,
   input  logic                                rd_en,
   output logic [FIFO_WIDTH-1:0]               data_out,
   output logic                                wr_ack,
   output logic                                overflow,
   output logic                                underflow,
   output logic                                full,
   output logic                                empty,
   output logic                                almostfull,
   output logic                                almostempty,
   output logic [count_width(FIFO_DEPTH)-1:0]  count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = count_width(FIFO_DEPTH);

   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  wr_ack_q, overflow_q, underflow_q;
   logic                  wr_acc, rd_acc;
   fifo_op_e              op;

   fifo_flag_gen #(
      .DEPTH     (FIFO_DEPTH),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH),
      .CW        (CW)
   ) u_flags (
      .count_i       (count_q),
      .full_o        (full),
      .empty_o       (empty),
      .almostfull_o  (almostfull),
      .almostempty_o (almostempty)
   );

   always_comb begin
      wr_acc   = wr_en && !full && !flush;
      rd_acc   = rd_en && !empty && !flush;
      op       = fifo_op_e'({wr_acc, rd_acc});
      wr_ptr_d = wr_acc ? PW'(ptr_next(32'(wr_ptr_q), FIFO_DEPTH)) : wr_ptr_q;
      rd_ptr_d = rd_acc ? PW'(ptr_next(32'(rd_ptr_q), FIFO_DEPTH)) : rd_ptr_q;
      count_d  = count_q;
      case (op)
         OP_WR:   count_d = count_q + CW'(1);
         OP_RD:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_acc)
         mem_q[wr_ptr_q] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (flush) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_ack_q    <= wr_acc;
         overflow_q  <= wr_en && !wr_acc;
         underflow_q <= rd_en && !rd_acc;
      end
   end

`ifdef FIFO_FWFT_EN
   assign data_out = mem_q[rd_ptr_q];
`else
   logic [FIFO_WIDTH-1:0] data_out_q;

   // Flush leaves the last read word on the output
   always_ff @(posedge clk) begin
      if (!rst_n)
         data_out_q <= '0;
      else if (rd_acc)
         data_out_q <= mem_q[rd_ptr_q];
   end

   assign data_out = data_out_q;
`endif

   assign wr_ack    = wr_ack_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign count     = count_q;

endmodule

// File: tb/tb_prog_sync_fifo.sv
// Scoreboard bench for prog_sync_fifo: depth-8 instance plus a depth-6 wrap instance.
module tb_prog_sync_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0, flush = 1'b0;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [15:0] data_in = '0, data_out;
   logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
   logic [3:0]  count;

   logic        wr6 = 1'b0, rd6 = 1'b0;
   logic [15:0] d6 = '0, data_out6;
   logic        ack6, ovf6, unf6, full6, empty6, af6, ae6;
   logic [2:0]  count6;

   int          vectors = 0;
   int          miscompares = 0;

   logic [15:0] sb[$];
   logic [15:0] q6[$];
   int          mcount = 0;
   logic [15:0] exp_dout = '0;

   always #5 clk = ~clk;

   prog_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
      .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
      .almostempty(almostempty), .count(count)
   );

   prog_sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr6), .data_in(d6),
      .rd_en(rd6), .data_out(data_out6), .wr_ack(ack6), .overflow(ovf6),
      .underflow(unf6), .full(full6), .empty(empty6), .almostfull(af6),
      .almostempty(ae6), .count(count6)
   );

   // Applies one cycle of stimulus and advances the reference model and scoreboard
   task automatic drive(input logic w, input logic [15:0] d, input logic r,
                        input logic f, input logic rn);
      logic wacc, racc;
      wr_en = w; data_in = d; rd_en = r; flush = f; rst_n = rn;
      if (!rn) begin
         sb.delete(); mcount = 0; exp_dout = '0;
      end else if (f) begin
         sb.delete(); mcount = 0;
      end else begin
         wacc = w && (mcount < 8);
         racc = r && (mcount > 0);
         if (racc) exp_dout = sb.pop_front();
         if (wacc) sb.push_back(d);
         mcount = mcount + int'(wacc) - int'(racc);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
      vectors++; if ({full, empty, almostfull, almostempty} !== 4'b0100) begin miscompares++; $display("FAIL reset_flags got %b exp 0100", {full, empty, almostfull, almostempty}); end
      vectors++; if ({wr_ack, overflow, underflow} !== 3'b000) begin miscompares++; $display("FAIL reset_hs got %b exp 000", {wr_ack, overflow, underflow}); end
`ifndef FIFO_FWFT_EN
      vectors++; if (data_out !== 16'h0) begin miscompares++; $display("FAIL reset_dout got %h exp 0000", data_out); end
`endif
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
         vectors++; if (wr_ack !== 1'b1) begin miscompares++; $display("FAIL fill_ack[%0d] got %b exp 1", i, wr_ack); end
         vectors++; if (count !== 4'(mcount)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, mcount); end
         vectors++; if (almostfull !== (i == 6 || i == 7)) begin miscompares++; $display("FAIL fill_af[%0d] got %b exp %b", i, almostfull, (i == 6 || i == 7)); end
         vectors++; if (full !== (i == 8)) begin miscompares++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 8)); end
      end
   endtask

   task automatic test_overflow();
      drive(1'b1, 16'h0009, 1'b0, 1'b0, 1'b1);
      vectors++; if ({wr_ack, overflow} !== 2'b01) begin miscompares++; $display("FAIL ovf_hs got %b exp 01", {wr_ack, overflow}); end
      vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_count got %0d exp 8", count); end
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_pulse got %b exp 0", overflow); end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
`ifdef FIFO_FWFT_EN
         if (sb.size() > 0) begin
            vectors++; if (data_out !== sb[0]) begin miscompares++; $display("FAIL drain_head[%0d] got %h exp %h", i, data_out, sb[0]); end
         end
`else
         vectors++; if (data_out !== exp_dout) begin miscompares++; $display("FAIL drain_data[%0d] got %h exp %h", i, data_out, exp_dout); end
`endif
         vectors++; if (count !== 4'(mcount)) begin miscompares++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, mcount); end
         vectors++; if (almostempty !== (mcount == 1)) begin miscompares++; $display("FAIL drain_ae[%0d] got %b exp %b", i, almostempty, (mcount == 1)); end
         vectors++; if (empty !== (mcount == 0)) begin miscompares++; $display("FAIL drain_empty[%0d] got %b exp %b", i, empty, (mcount == 0)); end
      end
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
      vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL unf_flag got %b exp 1", underflow); end
`ifndef FIFO_FWFT_EN
      vectors++; if (data_out !== 16'h0008) begin miscompares++; $display("FAIL unf_hold got %h exp 0008", data_out); end
`endif
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_wrap();
      logic [15:0] exp6;
      wr6 = 1'b1; d6 = 16'h0100; rd6 = 1'b0;
      q6.push_back(d6);
      @(posedge clk); #1;
      vectors++; if (count6 !== 3'd1) begin miscompares++; $display("FAIL wrap_prime got %0d exp 1", count6); end
      for (int k = 1; k <= 20; k++) begin
         wr6 = 1'b1; rd6 = 1'b1; d6 = 16'h0100 + 16'(k);
         exp6 = q6.pop_front();
         q6.push_back(d6);
         @(posedge clk); #1;
         vectors++; if (count6 !== 3'd1) begin miscompares++; $display("FAIL wrap_count[%0d] got %0d exp 1", k, count6); end
`ifdef FIFO_FWFT_EN
         vectors++; if (data_out6 !== q6[0]) begin miscompares++; $display("FAIL wrap_head[%0d] got %h exp %h", k, data_out6, q6[0]); end
`else
         vectors++; if (data_out6 !== exp6) begin miscompares++; $display("FAIL wrap_data[%0d] got %h exp %h", k, data_out6, exp6); end
`endif
      end
      wr6 = 1'b0; rd6 = 1'b0;
   endtask

   task automatic test_full_both();
      for (int i = 0; i < 8; i++) drive(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b1);
      drive(1'b1, 16'h0BAD, 1'b1, 1'b0, 1'b1);
      vectors++; if ({wr_ack, overflow} !== 2'b01) begin miscompares++; $display("FAIL fullboth_hs got %b exp 01", {wr_ack, overflow}); end
      vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL fullboth_count got %0d exp 7", count); end
`ifndef FIFO_FWFT_EN
      vectors++; if (data_out !== exp_dout) begin miscompares++; $display("FAIL fullboth_data got %h exp %h", data_out, exp_dout); end
`endif
      for (int i = 0; i < 7; i++) drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 16'h0C0C, 1'b1, 1'b0, 1'b1);
      vectors++; if ({wr_ack, underflow} !== 2'b11) begin miscompares++; $display("FAIL emptyboth_hs got %b exp 11", {wr_ack, underflow}); end
      vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL emptyboth_count got %0d exp 1", count); end
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
`ifndef FIFO_FWFT_EN
      vectors++; if (data_out !== 16'h0C0C) begin miscompares++; $display("FAIL emptyboth_data got %h exp 0c0c", data_out); end
`endif
   endtask

   task automatic test_flush();
      logic [15:0] held;
      for (int i = 0; i < 5; i++) drive(1'b1, 16'h0D00 + 16'(i), 1'b0, 1'b0, 1'b1);
      held = data_out;
      drive(1'b1, 16'h00AA, 1'b0, 1'b1, 1'b1);
      vectors++; if ({count, empty} !== {4'd0, 1'b1}) begin miscompares++; $display("FAIL flush_state got count %0d empty %b exp 0/1", count, empty); end
      vectors++; if (wr_ack !== 1'b0) begin miscompares++; $display("FAIL flush_ack got %b exp 0", wr_ack); end
`ifndef FIFO_FWFT_EN
      vectors++; if (data_out !== held) begin miscompares++; $display("FAIL flush_hold got %h exp %h", data_out, held); end
`endif
      drive(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
`ifndef FIFO_FWFT_EN
      vectors++; if (data_out !== exp_dout) begin miscompares++; $display("FAIL flush_after got %h exp %h", data_out, exp_dout); end
`endif
      vectors++; if (count !== 4'(mcount)) begin miscompares++; $display("FAIL flush_after_count got %0d exp %0d", count, mcount); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive(1'b1, 16'h0E00 + 16'(i), 1'b0, 1'b0, 1'b1);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 16'h0777, 1'b1, 1'b1, 1'b0);
      vectors++; if (count !== 4'd0 || empty !== 1'b1) begin miscompares++; $display("FAIL rstmid_state got count %0d empty %b exp 0/1", count, empty); end
      vectors++; if ({wr_ack, overflow, underflow} !== 3'b000) begin miscompares++; $display("FAIL rstmid_hs got %b exp 000", {wr_ack, overflow, underflow}); end
`ifndef FIFO_FWFT_EN
      vectors++; if (data_out !== 16'h0) begin miscompares++; $display("FAIL rstmid_dout got %h exp 0000", data_out); end
`endif
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_full_both();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
